// File: rtl/ccx_ic_xbar_if.sv
// Bundle of N request/response ports; the master side drives requests and the
// slave side answers with a same-cycle grant and a next-cycle response.
interface ccx_ic_xbar_if #(
  parameter int unsigned N  = 1,
  parameter int unsigned AW = 39,
  parameter int unsigned DW = 64
);
  localparam int unsigned SW = DW / 8;

  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    wen;
  logic [N*SW-1:0] strb;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    err;
  logic [N*DW-1:0] rdata;

  modport master (
    output req, addr, wen, strb, wdata,
    input  gnt, err, rdata
  );

  modport slave (
    input  req, addr, wen, strb, wdata,
    output gnt, err, rdata
  );
endinterface

// File: rtl/ccx_ic_xbar.sv
// NM x NS memory crossbar: base/mask decode, per-slave arbitration, 1-cycle response routing.
// Define CCX_IC_XBAR_RR_EN for per-slave round-robin; otherwise lowest master index wins.
module ccx_ic_xbar #(
  parameter int unsigned        NM     = 2,
  parameter int unsigned        NS     = 3,
  parameter int unsigned        AW     = 39,
  parameter int unsigned        DW     = 64,
  parameter logic [NS*AW-1:0]   S_BASE = '0,
  parameter logic [NS*AW-1:0]   S_MASK = '0
) (
  input  logic          g_clk,
  input  logic          g_reset,
  ccx_ic_xbar_if.slave  m,
  ccx_ic_xbar_if.master s
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned MW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned XW = (NS > 1) ? $clog2(NS) : 1;

  logic [NM-1:0] dec_miss;
  logic [XW-1:0] dec_sel [NM];
  logic [NM-1:0] cand    [NS];
  logic [NS-1:0] win_v;
  logic [MW-1:0] win_idx [NS];
  logic [NM-1:0] gnt;

  logic [NM-1:0] rsp_v_q,    rsp_v_d;
  logic [NM-1:0] rsp_miss_q, rsp_miss_d;
  logic [XW-1:0] rsp_sel_q [NM];
  logic [XW-1:0] rsp_sel_d [NM];

  // Address decode: lowest matching slave index wins, no match is a miss.
  always_comb begin
    for (int unsigned mi = 0; mi < NM; mi++) begin
      dec_miss[mi] = 1'b1;
      dec_sel[mi]  = '0;
      for (int unsigned si = 0; si < NS; si++) begin
        if (dec_miss[mi] &&
            ((m.addr[mi*AW +: AW] & S_MASK[si*AW +: AW]) == S_BASE[si*AW +: AW])) begin
          dec_miss[mi] = 1'b0;
          dec_sel[mi]  = XW'(si);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned si = 0; si < NS; si++) begin
      for (int unsigned mi = 0; mi < NM; mi++) begin
        cand[si][mi] = m.req[mi] && !dec_miss[mi] && !g_reset && (dec_sel[mi] == XW'(si));
      end
    end
  end

`ifdef CCX_IC_XBAR_RR_EN
  logic [MW-1:0] ptr_q [NS];
  logic [MW-1:0] ptr_d [NS];

  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned si = 0; si < NS; si++) begin
      win_v[si]   = 1'b0;
      win_idx[si] = '0;
      for (int unsigned k = 0; k < NM; k++) begin
        idx = (32'(ptr_q[si]) + k) % NM;
        if (!win_v[si] && cand[si][idx]) begin
          win_v[si]   = 1'b1;
          win_idx[si] = MW'(idx);
        end
      end
    end
  end

  // Pointer only advances on an accepted transfer, so a stalled winner stays put.
  always_comb begin
    for (int unsigned si = 0; si < NS; si++) begin
      ptr_d[si] = ptr_q[si];
      if (win_v[si] && s.gnt[si]) begin
        ptr_d[si] = (win_idx[si] == MW'(NM - 1)) ? '0 : win_idx[si] + 1'b1;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      ptr_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    for (int unsigned si = 0; si < NS; si++) begin
      win_v[si]   = 1'b0;
      win_idx[si] = '0;
      for (int unsigned mi = 0; mi < NM; mi++) begin
        if (!win_v[si] && cand[si][mi]) begin
          win_v[si]   = 1'b1;
          win_idx[si] = MW'(mi);
        end
      end
    end
  end
`endif

  // Slave-side request mux; payloads are zero whenever the slave is not requested.
  always_comb begin
    s.req   = '0;
    s.addr  = '0;
    s.wen   = '0;
    s.strb  = '0;
    s.wdata = '0;
    for (int unsigned si = 0; si < NS; si++) begin
      s.req[si] = win_v[si];
      for (int unsigned mi = 0; mi < NM; mi++) begin
        if (win_v[si] && (win_idx[si] == MW'(mi))) begin
          s.addr[si*AW +: AW]  = m.addr[mi*AW +: AW];
          s.wen[si]            = m.wen[mi];
          s.strb[si*SW +: SW]  = m.strb[mi*SW +: SW];
          s.wdata[si*DW +: DW] = m.wdata[mi*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int unsigned mi = 0; mi < NM; mi++) begin
      if (m.req[mi] && !g_reset) begin
        if (dec_miss[mi]) begin
          gnt[mi] = 1'b1;
        end else begin
          for (int unsigned si = 0; si < NS; si++) begin
            if ((dec_sel[mi] == XW'(si)) && win_v[si] &&
                (win_idx[si] == MW'(mi)) && s.gnt[si]) begin
              gnt[mi] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign m.gnt = gnt;

  always_comb begin
    rsp_v_d = gnt;
    for (int unsigned mi = 0; mi < NM; mi++) begin
      rsp_miss_d[mi] = gnt[mi] ? dec_miss[mi] : rsp_miss_q[mi];
      rsp_sel_d[mi]  = gnt[mi] ? dec_sel[mi]  : rsp_sel_q[mi];
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rsp_v_q    <= '0;
      rsp_miss_q <= '0;
      rsp_sel_q  <= '{default: '0};
    end else begin
      rsp_v_q    <= rsp_v_d;
      rsp_miss_q <= rsp_miss_d;
      rsp_sel_q  <= rsp_sel_d;
    end
  end

  // Reset also masks the response combinationally so an in-flight reply is dropped at once.
  always_comb begin
    m.rdata = '0;
    m.err   = '0;
    for (int unsigned mi = 0; mi < NM; mi++) begin
      if (rsp_v_q[mi] && !g_reset) begin
        if (rsp_miss_q[mi]) begin
          m.err[mi] = 1'b1;
        end else begin
          for (int unsigned si = 0; si < NS; si++) begin
            if (rsp_sel_q[mi] == XW'(si)) begin
              m.rdata[mi*DW +: DW] = s.rdata[si*DW +: DW];
              m.err[mi]            = s.err[si];
            end
          end
        end
      end
    end
  end
endmodule
